// File: rtl/bram_dp.sv
// bram_dp: simple dual-port block RAM with one write port and one read port on
// a single clock. Supports per-byte write enables, selectable read-during-write
// behaviour, 1- or 2-cycle registered read latency with a valid strobe, and a
// zero-fill sweep of every word after reset.
module bram_dp #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned RDW_MODE   = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   addr_in,
   input  logic                wr_en,
   input  logic [DATA_W/8-1:0] be,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [ADDR_W-1:0]   addr_out,
   input  logic                rd_en,
   output logic [DATA_W-1:0]   data_out,
   output logic                rd_valid,
   output logic                init_busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned NB    = DATA_W / 8;

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] cnt_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] merged_word;
   logic [DATA_W-1:0] rd_word;
   logic              rd_fire;
   logic              wr_fire;

   // State and sweep counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: sweep every address once, then hand the ports to the user.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      init_busy = 1'b0;
      case (state_q)
         CLEAR: begin
            init_busy = 1'b1;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (&cnt_q) begin
               state_d = RUN;
            end
         end
         RUN: begin
            init_busy = 1'b0;
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   assign rd_fire = (state_q == RUN) && rd_en;
   assign wr_fire = (state_q == RUN) && wr_en;

   // Read word selection, including the optional same-address forwarding path.
   always_comb begin
      old_word    = mem[addr_out];
      merged_word = old_word;
      for (int unsigned i = 0; i < NB; i++) begin
         if (be[i]) begin
            merged_word[8*i +: 8] = data_in[8*i +: 8];
         end
      end
      rd_word = old_word;
      if ((RDW_MODE == 1) && wr_fire && (addr_out == addr_in)) begin
         rd_word = merged_word;
      end
   end

   // Memory array: zero-fill during the sweep, byte-masked user writes afterwards.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[cnt_q] <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
               mem[addr_in][8*i +: 8] <= data_in[8*i +: 8];
            end
         end
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic              p_valid;
         logic [DATA_W-1:0] p_data;

         // First read stage: capture the array word.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               p_valid <= 1'b0;
               p_data  <= '0;
            end else begin
               p_valid <= rd_fire;
               if (rd_fire) begin
                  p_data <= rd_word;
               end
            end
         end

         // Output stage: present the result and hold it until the next one.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_valid <= 1'b0;
               data_out <= '0;
            end else begin
               rd_valid <= p_valid;
               if (p_valid) begin
                  data_out <= p_data;
               end
            end
         end
      end else begin : g_lat1
         // Single output stage: present the result and hold it until the next one.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_valid <= 1'b0;
               data_out <= '0;
            end else begin
               rd_valid <= rd_fire;
               if (rd_fire) begin
                  data_out <= rd_word;
               end
            end
         end
      end
   endgenerate

endmodule

// File: doc/bram_dp.md
Name: bram_dp

Overview:
- Parametrised simple dual-port block RAM: one write port and one independent read port on a single clock.
- Adds the following over the fixed 8-bit × 256 RAM:
  - configurable width and depth;
  - per-byte write enables;
  - selectable read-during-write behaviour;
  - 1- or 2-cycle read latency with a read-valid strobe;
  - a post-reset zero-fill sweep.
- Used as the generic buffer primitive for line buffers and FIFOs in the datapath.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, read-during-write to the same address: 0 = return old data, 1 = return new (forwarded) data

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
addr_in  input  ADDR_W  write address
wr_en  input  1  write enable
be  input  DATA_W/8  byte enables; bit i covers data_in[8i+7:8i]
data_in  input  DATA_W  write data
addr_out  input  ADDR_W  read address
rd_en  input  1  read enable
data_out  output  DATA_W  read data; registered
rd_valid  output  1  high for exactly one cycle when data_out carries a new read result
init_busy  output  1  high while the zero-fill sweep is running; port requests are ignored

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_out = 0, rd_valid = 0, pipeline valid bits = 0;
  - init_busy = 1, FSM = CLEAR, sweep counter = 0.
  - Memory contents are not reset directly.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt.
  - When cnt == DEPTH-1 is written, go to RUN on the next edge; init_busy falls in the same edge.
  - The sweep takes exactly DEPTH cycles after rst_n deasserts.
- In CLEAR:
  - wr_en and rd_en are ignored; no user write lands and no read is issued;
  - rd_valid stays 0 and data_out stays 0.
- RUN, write: on an edge with wr_en = 1, only bytes with be[i] = 1 are updated at addr_in. If wr_en = 1 and be = 0, nothing changes.
- RUN, read: rd_en sampled on edge N.
  - RD_LATENCY = 1: data_out and rd_valid are updated at edge N+1 (visible in cycle N+1).
  - RD_LATENCY = 2: an extra output register; result and rd_valid appear one edge later (N+2).
  - Back-to-back reads are fully pipelined; one result per cycle.
- When no read completes, rd_valid = 0 and data_out holds its last value.
- Read-during-write, same edge and addr_out == addr_in with wr_en = 1:
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: returns the merged word — enabled bytes from data_in, the others from the old contents.
  - Different addresses never interact.
- Write followed by read of the same address on the next edge returns the written data in both modes.
- Address wrap: addresses are exactly ADDR_W bits; no out-of-range case exists.
- Reset mid-operation:
  - in-flight reads are discarded (rd_valid = 0, no late valid after release);
  - the sweep restarts from address 0 even if the previous sweep was incomplete.
- Reset during CLEAR restarts the sweep from 0.
- rd_en together with wr_en at different addresses in the same cycle is fully legal.

Test Plan:
- Setup for all scenarios: DATA_W = 16, ADDR_W = 4, RD_LATENCY = 1, RDW_MODE = 0 unless stated.
- Zero-fill sweep: release rst_n → init_busy high for exactly 16 cycles. Read all 16 addresses → every data_out = 0x0000, each with a single-cycle rd_valid.
- Basic write/read: write 0x1234 at addr 1, then 0xABCD at addr 2. Read addr 1 then addr 2 on consecutive cycles → data_out = 0x1234 then 0xABCD, rd_valid high for 2 consecutive cycles, each 1 cycle after rd_en.
- Byte enables: write 0xFFFF be = 2'b11 at addr 3, then 0x00AA be = 2'b01 at addr 3 → read returns 0xFFAA. A write with be = 2'b00 leaves it at 0xFFAA.
- Read-during-write, addr 5 holding 0x1111; write 0x2222 be = 2'b11 and read addr 5 on the same edge:
  - RDW_MODE = 0 → 0x1111;
  - RDW_MODE = 1 → 0x2222;
  - RDW_MODE = 1 with be = 2'b10 → 0x2211.
- RD_LATENCY = 2: read addr 1 holding 0x1234 → rd_valid and data_out = 0x1234 appear 2 cycles after rd_en. Four back-to-back reads → 4 consecutive valid cycles.
- Reset mid-operation: issue rd_en, assert rst_n low before the result appears → rd_valid stays 0 through and after reset. init_busy is re-asserted, and a later read of any address returns 0x0000.
- Requests during CLEAR: wr_en and rd_en asserted while init_busy = 1 → no rd_valid, and the target address reads 0x0000 after the sweep.
